// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button scan controller: the per-channel state
// encoding and the default timing constants for a 100 MHz system clock.
//   DEF_TICK_CYC     : clock cycles per sample tick (1 ms at 100 MHz)
//   DEF_STABLE_TICKS : consecutive differing samples needed to flip a level
//   DEF_LONG_TICKS   : ticks a press must be held to count as a long press
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } btn_state_e;

    localparam int DEF_TICK_CYC     = 100000;
    localparam int DEF_STABLE_TICKS = 10;
    localparam int DEF_LONG_TICKS   = 1000;

endpackage

// File: rtl/btn_chan.sv
// -----------------------------------------------------------------------------
// btn_chan
// One button channel: two-flop synchroniser, tick-sampled debounce counter,
// hold counter and a press / long-press / release classifier.
// Ports:
//   i_clk      : system clock
//   i_rst_n    : asynchronous active-low reset
//   i_tick     : shared one-cycle sample strobe from the prescaler
//   i_btn      : raw asynchronous button pin, active high
//   o_dboun    : debounced level
//   o_press    : one-cycle pulse on the debounced rising edge
//   o_release  : one-cycle pulse on the debounced falling edge
//   o_long     : one-cycle pulse once a press has been held LONG_TICKS ticks
// -----------------------------------------------------------------------------
module btn_chan
    import btn_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_dboun,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int STAB_W = $clog2(STABLE_TICKS + 1);
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_dboun;
    logic [STAB_W-1:0] r_stab_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    btn_state_e        r_state;
    logic              r_press;
    logic              r_release;
    logic              r_long;

    logic w_differs;
    logic w_flip;
    logic w_rise;
    logic w_fall;

    // The synchronised sample disagrees with the debounced level; when that
    // happens on a tick that completes the stability run, the level flips on
    // this edge. The FSM sees the same flip so its pulses line up with it.
    assign w_differs = (r_sync2 != r_dboun);
    assign w_flip    = i_tick & w_differs & (r_stab_cnt == STAB_LAST);
    assign w_rise    = w_flip &  r_sync2;
    assign w_fall    = w_flip & ~r_sync2;

    // Two-flop synchroniser: the only place the raw pin is read, so the
    // metastable first stage never reaches any decision logic.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: on each tick, count consecutive samples that differ from the
    // debounced level. A single agreeing sample (a bounce) restarts the run.
    // Completing the run adopts the new level and clears the counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dboun    <= 1'b0;
            r_stab_cnt <= '0;
        end else if (i_tick) begin
            if (!w_differs) begin
                r_stab_cnt <= '0;
            end else if (w_flip) begin
                r_stab_cnt <= '0;
                r_dboun    <= r_sync2;
            end else begin
                r_stab_cnt <= r_stab_cnt + STAB_W'(1);
            end
        end
    end

    // Event classifier. Pulses are registered and default low every cycle.
    // A falling level is checked before the long-press threshold so a
    // release on the threshold tick wins and no long pulse is emitted.
    // In LONG_HELD the hold counter stays frozen so the long pulse cannot
    // repeat within one press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state    <= PRESSED;
                        r_press    <= 1'b1;
                        r_hold_cnt <= '0;
                    end
                end
                PRESSED: begin
                    if (w_fall) begin
                        r_state   <= IDLE;
                        r_release <= 1'b1;
                    end else if (i_tick) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_long  <= 1'b1;
                            r_state <= LONG_HELD;
                        end
                    end
                end
                LONG_HELD: begin
                    if (w_fall) begin
                        r_state   <= IDLE;
                        r_release <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_dboun   = r_dboun;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule

// File: rtl/btn_scan_ctrl.sv
// -----------------------------------------------------------------------------
// btn_scan_ctrl
// Debounce controller for N_BTN push-buttons sharing one sample timebase.
// A single prescaler produces TICK, which every channel uses to sample its
// synchronised button, so no channel needs its own wide timer.
// Ports:
//   CLK          : system clock (100 MHz)
//   RST_N        : asynchronous active-low reset
//   BTN          : raw button pins, active high
//   BTN_DBOUN    : debounced levels
//   BTN_PRESS    : one-cycle pulses on debounced rising edges
//   BTN_RELEASE  : one-cycle pulses on debounced falling edges
//   BTN_LONG     : one-cycle pulses on long presses, at most once per press
//   TICK         : one-cycle sample strobe, exported for other consumers
// -----------------------------------------------------------------------------
module btn_scan_ctrl
    import btn_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int TICK_CYC     = DEF_TICK_CYC,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_BTN-1:0] BTN,
    output logic [N_BTN-1:0] BTN_DBOUN,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_RELEASE,
    output logic [N_BTN-1:0] BTN_LONG,
    output logic             TICK
);

    localparam int PRESC_W = $clog2(TICK_CYC);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYC - 1);

    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;

    // The strobe is a decode of the counter's terminal value, so it is high
    // for exactly one cycle per period and low while the counter sits at 0
    // in reset.
    assign w_tick = (r_presc == PRESC_LAST);
    assign TICK   = w_tick;

    // Prescaler: free-running 0..TICK_CYC-1, wrapping on the strobe cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // One independent channel per button; all share the same strobe, so
    // simultaneous edges produce simultaneous pulses without arbitration.
    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS)
        ) u_chan (
            .i_clk     (CLK),
            .i_rst_n   (RST_N),
            .i_tick    (w_tick),
            .i_btn     (BTN[g]),
            .o_dboun   (BTN_DBOUN[g]),
            .o_press   (BTN_PRESS[g]),
            .o_release (BTN_RELEASE[g]),
            .o_long    (BTN_LONG[g])
        );
    end

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btn_scan_ctrl
// Scoreboard bench for btn_scan_ctrl with short timing parameters.
// Expected pulse events are queued when a button is driven; every observed
// pulse cycle is recorded and then matched against the queue in order.
// -----------------------------------------------------------------------------
module tb_btn_scan_ctrl;

    localparam int N    = 4;
    localparam int TCYC = 10;
    localparam int STAB = 4;
    localparam int LONG = 20;
    localparam int LAT_LO = (STAB - 1) * TCYC + 3;
    localparam int LAT_HI = STAB * TCYC + 3;

    typedef struct {
        int           cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] lng;
        logic [N-1:0] dboun;
    } obs_t;

    typedef struct {
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] lng;
        logic [N-1:0] dboun;
        int           lo;
        int           hi;
        bit           relPrev;
    } exp_t;

    logic         CLK;
    logic         RST_N;
    logic [N-1:0] BTN;
    logic [N-1:0] BTN_DBOUN;
    logic [N-1:0] BTN_PRESS;
    logic [N-1:0] BTN_RELEASE;
    logic [N-1:0] BTN_LONG;
    logic         TICK;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [N-1:0] dbounSeen;
    obs_t         obsQ[$];
    exp_t         expQ[$];

    btn_scan_ctrl #(
        .N_BTN        (N),
        .TICK_CYC     (TCYC),
        .STABLE_TICKS (STAB),
        .LONG_TICKS   (LONG)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .BTN         (BTN),
        .BTN_DBOUN   (BTN_DBOUN),
        .BTN_PRESS   (BTN_PRESS),
        .BTN_RELEASE (BTN_RELEASE),
        .BTN_LONG    (BTN_LONG),
        .TICK        (TICK)
    );

    // 100 MHz-style clock; outputs are sampled on the falling edge.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance n cycles, sampling on each falling edge. Any cycle with a pulse
    // is logged with its cycle number so the tests can match it later.
    task automatic stepCycles(input int n);
        obs_t o;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            cyc++;
            dbounSeen = dbounSeen | BTN_DBOUN;
            if ((BTN_PRESS | BTN_RELEASE | BTN_LONG) != '0) begin
                o.cyc   = cyc;
                o.press = BTN_PRESS;
                o.rel   = BTN_RELEASE;
                o.lng   = BTN_LONG;
                o.dboun = BTN_DBOUN;
                obsQ.push_back(o);
            end
        end
    endtask

    // Queue one expected pulse cycle. With relPrev set the window is an
    // offset from the previously matched event instead of absolute.
    task automatic expectEvent(input logic [N-1:0] press, input logic [N-1:0] rel,
                               input logic [N-1:0] lng, input logic [N-1:0] dboun,
                               input int lo, input int hi, input bit relPrev);
        exp_t e;
        e.press   = press;
        e.rel     = rel;
        e.lng     = lng;
        e.dboun   = dboun;
        e.lo      = lo;
        e.hi      = hi;
        e.relPrev = relPrev;
        expQ.push_back(e);
    endtask

    // Held buttons through reset: outputs stay zero, TICK first appears in the
    // cycle ending on the 10th edge, and the level rises on the 4th tick edge.
    task automatic test_reset();
        int   r;
        int   firstTick;
        int   lo;
        int   hi;
        int   last;
        exp_t e;
        obs_t o;
        BTN   = '1;
        RST_N = 1'b0;
        for (int i = 0; i < 7; i++) begin
            stepCycles(1);
            checks++;
            if ({BTN_DBOUN, BTN_PRESS, BTN_RELEASE, BTN_LONG, TICK} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_outputs: got dboun=%b press=%b rel=%b long=%b tick=%b, expected all 0",
                         BTN_DBOUN, BTN_PRESS, BTN_RELEASE, BTN_LONG, TICK);
            end
        end
        RST_N = 1'b1;
        r = cyc;
        expectEvent('1, '0, '0, '1, r + STAB * TCYC, r + STAB * TCYC, 1'b0);
        firstTick = -1;
        for (int i = 0; i < 2 * TCYC && firstTick < 0; i++) begin
            stepCycles(1);
            if (TICK === 1'b1) firstTick = cyc - r;
        end
        checks++;
        if (firstTick != TCYC - 1) begin
            errors++;
            $display("[TB] FAIL first_tick: got TICK after %0d edges, expected after %0d edges",
                     firstTick, TCYC - 1);
        end
        stepCycles(r + STAB * TCYC - 1 - cyc);
        checks++;
        if (BTN_DBOUN !== '0) begin
            errors++;
            $display("[TB] FAIL reset_early_dboun: got %b, expected 0000", BTN_DBOUN);
        end
        stepCycles(1);
        checks++;
        if (BTN_DBOUN !== '1) begin
            errors++;
            $display("[TB] FAIL reset_dboun: got %b, expected 1111", BTN_DBOUN);
        end
        stepCycles(5);
        BTN = '0;
        expectEvent('0, '1, '0, '0, cyc + LAT_LO, cyc + LAT_HI, 1'b0);
        stepCycles(60);
        last = 0;
        while (expQ.size() > 0) begin
            e  = expQ.pop_front();
            lo = e.relPrev ? last + e.lo : e.lo;
            hi = e.relPrev ? last + e.hi : e.hi;
            checks++;
            if (obsQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL reset_event: got no pulse, expected press=%b rel=%b long=%b in %0d..%0d",
                         e.press, e.rel, e.lng, lo, hi);
            end else begin
                o = obsQ.pop_front();
                if ({o.press, o.rel, o.lng, o.dboun} !== {e.press, e.rel, e.lng, e.dboun}) begin
                    errors++;
                    $display("[TB] FAIL reset_event: got press=%b rel=%b long=%b dboun=%b, expected %b %b %b %b",
                             o.press, o.rel, o.lng, o.dboun, e.press, e.rel, e.lng, e.dboun);
                end
                checks++;
                if (o.cyc < lo || o.cyc > hi) begin
                    errors++;
                    $display("[TB] FAIL reset_timing: got cycle %0d, expected %0d..%0d", o.cyc, lo, hi);
                end
                last = o.cyc;
            end
        end
        checks++;
        if (obsQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL reset_extra: got %0d unexpected pulse cycles (first at %0d), expected 0",
                     obsQ.size(), obsQ[0].cyc);
            obsQ.delete();
        end
    endtask

    // Single clean press and release on channel 0.
    task automatic test_clean_press();
        int   lo;
        int   hi;
        int   last;
        exp_t e;
        obs_t o;
        BTN[0] = 1'b1;
        expectEvent(4'b0001, '0, '0, 4'b0001, cyc + LAT_LO, cyc + LAT_HI, 1'b0);
        stepCycles(50);
        checks++;
        if (BTN_DBOUN !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL press_level: got %b, expected 0001", BTN_DBOUN);
        end
        BTN[0] = 1'b0;
        expectEvent('0, 4'b0001, '0, '0, cyc + LAT_LO, cyc + LAT_HI, 1'b0);
        stepCycles(50);
        last = 0;
        while (expQ.size() > 0) begin
            e  = expQ.pop_front();
            lo = e.relPrev ? last + e.lo : e.lo;
            hi = e.relPrev ? last + e.hi : e.hi;
            checks++;
            if (obsQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL press_event: got no pulse, expected press=%b rel=%b long=%b in %0d..%0d",
                         e.press, e.rel, e.lng, lo, hi);
            end else begin
                o = obsQ.pop_front();
                if ({o.press, o.rel, o.lng, o.dboun} !== {e.press, e.rel, e.lng, e.dboun}) begin
                    errors++;
                    $display("[TB] FAIL press_event: got press=%b rel=%b long=%b dboun=%b, expected %b %b %b %b",
                             o.press, o.rel, o.lng, o.dboun, e.press, e.rel, e.lng, e.dboun);
                end
                checks++;
                if (o.cyc < lo || o.cyc > hi) begin
                    errors++;
                    $display("[TB] FAIL press_timing: got cycle %0d, expected %0d..%0d", o.cyc, lo, hi);
                end
                last = o.cyc;
            end
        end
        checks++;
        if (obsQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL press_extra: got %0d unexpected pulse cycles (first at %0d), expected 0",
                     obsQ.size(), obsQ[0].cyc);
            obsQ.delete();
        end
    endtask

    // Channel 1 toggles every 15 cycles: never more than two differing ticks
    // in a row, so nothing may be reported.
    task automatic test_bounce();
        dbounSeen = '0;
        for (int i = 0; i < 20; i++) begin
            BTN[1] = ~BTN[1];
            stepCycles(15);
        end
        BTN[1] = 1'b0;
        stepCycles(60);
        checks++;
        if (dbounSeen[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bounce_level: got dboun[1]=1 at some point, expected always 0");
        end
        checks++;
        if (obsQ.size() != 0 || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL bounce_pulses: got %0d pulse cycles, expected 0", obsQ.size());
            obsQ.delete();
            expQ.delete();
        end
    endtask

    // Channel 2 held 300 cycles: one long pulse exactly 20 ticks after the
    // press, then one release when the level falls.
    task automatic test_long_press();
        int   lo;
        int   hi;
        int   last;
        exp_t e;
        obs_t o;
        BTN[2] = 1'b1;
        expectEvent(4'b0100, '0, '0, 4'b0100, cyc + LAT_LO, cyc + LAT_HI, 1'b0);
        expectEvent('0, '0, 4'b0100, 4'b0100, LONG * TCYC, LONG * TCYC, 1'b1);
        stepCycles(300);
        BTN[2] = 1'b0;
        expectEvent('0, 4'b0100, '0, '0, cyc + LAT_LO, cyc + LAT_HI, 1'b0);
        stepCycles(60);
        last = 0;
        while (expQ.size() > 0) begin
            e  = expQ.pop_front();
            lo = e.relPrev ? last + e.lo : e.lo;
            hi = e.relPrev ? last + e.hi : e.hi;
            checks++;
            if (obsQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL long_event: got no pulse, expected press=%b rel=%b long=%b in %0d..%0d",
                         e.press, e.rel, e.lng, lo, hi);
            end else begin
                o = obsQ.pop_front();
                if ({o.press, o.rel, o.lng, o.dboun} !== {e.press, e.rel, e.lng, e.dboun}) begin
                    errors++;
                    $display("[TB] FAIL long_event: got press=%b rel=%b long=%b dboun=%b, expected %b %b %b %b",
                             o.press, o.rel, o.lng, o.dboun, e.press, e.rel, e.lng, e.dboun);
                end
                checks++;
                if (o.cyc < lo || o.cyc > hi) begin
                    errors++;
                    $display("[TB] FAIL long_timing: got cycle %0d, expected %0d..%0d", o.cyc, lo, hi);
                end
                last = o.cyc;
            end
        end
        checks++;
        if (obsQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL long_extra: got %0d unexpected pulse cycles (first at %0d), expected 0",
                     obsQ.size(), obsQ[0].cyc);
            obsQ.delete();
        end
    endtask

    // All four buttons change in one cycle: each pulse cycle carries all bits.
    task automatic test_simultaneous();
        int   lo;
        int   hi;
        int   last;
        exp_t e;
        obs_t o;
        BTN = '1;
        expectEvent('1, '0, '0, '1, cyc + LAT_LO, cyc + LAT_HI, 1'b0);
        stepCycles(60);
        BTN = '0;
        expectEvent('0, '1, '0, '0, cyc + LAT_LO, cyc + LAT_HI, 1'b0);
        stepCycles(60);
        last = 0;
        while (expQ.size() > 0) begin
            e  = expQ.pop_front();
            lo = e.relPrev ? last + e.lo : e.lo;
            hi = e.relPrev ? last + e.hi : e.hi;
            checks++;
            if (obsQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL simul_event: got no pulse, expected press=%b rel=%b long=%b in %0d..%0d",
                         e.press, e.rel, e.lng, lo, hi);
            end else begin
                o = obsQ.pop_front();
                if ({o.press, o.rel, o.lng, o.dboun} !== {e.press, e.rel, e.lng, e.dboun}) begin
                    errors++;
                    $display("[TB] FAIL simul_event: got press=%b rel=%b long=%b dboun=%b, expected %b %b %b %b",
                             o.press, o.rel, o.lng, o.dboun, e.press, e.rel, e.lng, e.dboun);
                end
                checks++;
                if (o.cyc < lo || o.cyc > hi) begin
                    errors++;
                    $display("[TB] FAIL simul_timing: got cycle %0d, expected %0d..%0d", o.cyc, lo, hi);
                end
                last = o.cyc;
            end
        end
        checks++;
        if (obsQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL simul_extra: got %0d unexpected pulse cycles (first at %0d), expected 0",
                     obsQ.size(), obsQ[0].cyc);
            obsQ.delete();
        end
    endtask

    // Reset while channel 3 is in LONG_HELD: outputs clear at once, no release
    // is reported, and the still-held button is pressed again on the 4th tick.
    task automatic test_reset_mid_hold();
        int   r;
        int   lo;
        int   hi;
        int   last;
        exp_t e;
        obs_t o;
        BTN[3] = 1'b1;
        expectEvent(4'b1000, '0, '0, 4'b1000, cyc + LAT_LO, cyc + LAT_HI, 1'b0);
        expectEvent('0, '0, 4'b1000, 4'b1000, LONG * TCYC, LONG * TCYC, 1'b1);
        stepCycles(260);
        RST_N = 1'b0;
        #1;
        checks++;
        if ({BTN_DBOUN, BTN_PRESS, BTN_RELEASE, BTN_LONG, TICK} !== '0) begin
            errors++;
            $display("[TB] FAIL midhold_async_clear: got dboun=%b press=%b rel=%b long=%b tick=%b, expected all 0",
                     BTN_DBOUN, BTN_PRESS, BTN_RELEASE, BTN_LONG, TICK);
        end
        stepCycles(5);
        RST_N = 1'b1;
        r = cyc;
        expectEvent(4'b1000, '0, '0, 4'b1000, r + STAB * TCYC, r + STAB * TCYC, 1'b0);
        stepCycles(60);
        BTN[3] = 1'b0;
        expectEvent('0, 4'b1000, '0, '0, cyc + LAT_LO, cyc + LAT_HI, 1'b0);
        stepCycles(60);
        last = 0;
        while (expQ.size() > 0) begin
            e  = expQ.pop_front();
            lo = e.relPrev ? last + e.lo : e.lo;
            hi = e.relPrev ? last + e.hi : e.hi;
            checks++;
            if (obsQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL midhold_event: got no pulse, expected press=%b rel=%b long=%b in %0d..%0d",
                         e.press, e.rel, e.lng, lo, hi);
            end else begin
                o = obsQ.pop_front();
                if ({o.press, o.rel, o.lng, o.dboun} !== {e.press, e.rel, e.lng, e.dboun}) begin
                    errors++;
                    $display("[TB] FAIL midhold_event: got press=%b rel=%b long=%b dboun=%b, expected %b %b %b %b",
                             o.press, o.rel, o.lng, o.dboun, e.press, e.rel, e.lng, e.dboun);
                end
                checks++;
                if (o.cyc < lo || o.cyc > hi) begin
                    errors++;
                    $display("[TB] FAIL midhold_timing: got cycle %0d, expected %0d..%0d", o.cyc, lo, hi);
                end
                last = o.cyc;
            end
        end
        checks++;
        if (obsQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL midhold_extra: got %0d unexpected pulse cycles (first at %0d), expected 0",
                     obsQ.size(), obsQ[0].cyc);
            obsQ.delete();
        end
    endtask

    // Test sequence.
    initial begin
        RST_N     = 1'b0;
        BTN       = '0;
        dbounSeen = '0;
        $display("[TB] starting btn_scan_ctrl bench");
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_simultaneous();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_scan_ctrl.md
Name: btn_scan_ctrl

Overview:
- Shared-timebase debounce controller for N_BTN board push-buttons on the Arty A7 (100 MHz CLK).
- One prescaler produces a sample tick that is shared by every button channel, instead of one wide counter per button.
- Each channel synchronises its button, debounces it on ticks and classifies events: press, release, long-press.
- Sits between the raw BTN pins and the user logic, replacing per-button debouncers.

Parameters:
- N_BTN, 4, number of button channels.
- TICK_CYC, 100000, CLK cycles per sample tick (1 ms at 100 MHz); must be >= 2.
- STABLE_TICKS, 10, consecutive differing samples required to change the debounced level; must be >= 1.
- LONG_TICKS, 1000, ticks the debounced level must stay high to flag a long press; must be >= 1.

Ports:
- CLK  input  1  system clock, 100 MHz.
- RST_N  input  1  asynchronous active-low reset.
- BTN  input  N_BTN  raw asynchronous button pins, active high.
- BTN_DBOUN  output  N_BTN  debounced level.
- BTN_PRESS  output  N_BTN  one-CLK pulse on debounced rising edge.
- BTN_RELEASE  output  N_BTN  one-CLK pulse on debounced falling edge.
- BTN_LONG  output  N_BTN  one-CLK pulse, at most once per press.
- TICK  output  1  one-CLK sample strobe, exported for other consumers.

Behaviour:
- Reset is asynchronous and active-low. While RST_N=0, all outputs, synchroniser flops, prescaler and per-channel counters are 0 and every FSM is in IDLE.
- Synchroniser: BTN[i] passes through 2 flops to give s[i]. No other logic reads BTN directly.
- Prescaler: counts 0..TICK_CYC-1 and wraps.
  - TICK=1 for exactly the cycle in which the count equals TICK_CYC-1.
  - After reset is released, the first TICK occurs on the TICK_CYC-th rising edge.
- Per-channel debounce, evaluated only on TICK cycles:
  - If s[i] != BTN_DBOUN[i], increment stab_cnt[i].
  - If s[i] == BTN_DBOUN[i], clear stab_cnt[i]. Any bounce restarts the count.
  - When the increment would reach STABLE_TICKS: BTN_DBOUN[i] <= s[i] and stab_cnt[i] <= 0, registered on that same TICK edge.
  - Width of stab_cnt = clog2(STABLE_TICKS+1).
- Per-channel FSM; states IDLE, PRESSED, LONG_HELD:
  - IDLE -> PRESSED when the debounced level rises. BTN_PRESS[i] pulses for 1 cycle, aligned with the BTN_DBOUN rise. hold_cnt[i] <= 0.
  - PRESSED: hold_cnt[i] increments on each TICK. When the increment reaches LONG_TICKS, BTN_LONG[i] pulses for 1 cycle and the FSM moves to LONG_HELD.
  - LONG_HELD: hold_cnt frozen, no further BTN_LONG pulses.
  - PRESSED or LONG_HELD -> IDLE when the debounced level falls. BTN_RELEASE[i] pulses for 1 cycle, aligned with the BTN_DBOUN fall.
  - If the level falls on the same TICK that hold_cnt reaches LONG_TICKS, the release takes priority: no BTN_LONG pulse.
  - Width of hold_cnt = clog2(LONG_TICKS+1).
- Latency:
  - A clean edge on BTN is reflected on BTN_DBOUN after STABLE_TICKS ticks.
  - Absolute delay is between (STABLE_TICKS-1)*TICK_CYC+3 and STABLE_TICKS*TICK_CYC+3 CLK cycles, depending on the edge's phase relative to TICK.
- Channels are fully independent. Simultaneous edges on several channels produce simultaneous pulses, with no arbitration or serialisation.
- Reset during operation:
  - Outputs clear immediately (asynchronously).
  - No release pulse is generated.
  - After reset is released with a button still held, a normal press is detected after STABLE_TICKS ticks.
- Pulses are never emitted outside TICK-derived edges. BTN_PRESS, BTN_RELEASE and BTN_LONG are mutually exclusive per channel in any cycle.

Decomposition:
- Shared package btn_pkg holds:
  - the state encoding (IDLE=2'd0, PRESSED=2'd1, LONG_HELD=2'd2);
  - the default timing constants for 100 MHz (TICK_CYC, STABLE_TICKS, LONG_TICKS).
- Sub-module btn_chan: synchroniser, stab_cnt, hold_cnt and FSM for one channel. Inputs CLK, RST_N, TICK, BTN bit; outputs the four per-channel signals.
- Top level btn_scan_ctrl contains the prescaler plus a generate loop of N_BTN btn_chan instances.

Test Plan (bench parameters TICK_CYC=10, STABLE_TICKS=4, LONG_TICKS=20, N_BTN=4):
1. Reset:
   - Stimulus: RST_N=0 for 7 cycles with BTN=4'b1111, then release.
   - Required: all outputs 0 during reset; first TICK on the 10th rising edge after release; BTN_DBOUN=4'b1111 only after 4 ticks.
2. Clean press:
   - Stimulus: BTN[0] 0->1 and held.
   - Required: BTN_DBOUN[0] rises 33..43 cycles later; exactly one BTN_PRESS[0] pulse in the same cycle; bits 3:1 stay 0.
3. Bounce rejection:
   - Stimulus: BTN[1] toggled every 15 cycles for 300 cycles, then held 0.
   - Required: BTN_DBOUN[1] stays 0; zero PRESS and zero RELEASE pulses.
4. Long press:
   - Stimulus: BTN[2] held for 300 cycles, then released.
   - Required: one BTN_LONG[2] pulse 200 cycles (20 ticks) after the BTN_DBOUN[2] rise; no second BTN_LONG pulse; one BTN_RELEASE[2] pulse when the debounced level falls.
5. Simultaneous press:
   - Stimulus: BTN 4'b0000 -> 4'b1111 in one cycle.
   - Required: all four BTN_DBOUN bits and four BTN_PRESS bits assert in the same cycle.
6. Reset mid-hold:
   - Stimulus: RST_N pulsed low while BTN[3] is in LONG_HELD.
   - Required: outputs 0 immediately; no RELEASE pulse; with BTN[3] still 1, BTN_PRESS[3] fires again 4 ticks after reset release.
